pcf_i2c_target: RTL

- I2C target (responder) emulating the PCF8574 8-bit I/O expander behind the LCD backpack.
- Counterpart of the I2C initiator/controller pair that drives the LCD. It sits on the same SCL/SDA bus as that initiator, in simulation benches or in an on-chip loopback.
- Oversamples SCL/SDA on the system clock, ACKs its address, latches write bytes onto a parallel port and returns an input port on reads.
- Optionally decodes HD44780 4-bit nibble traffic into characters and commands.

---
 rtl/pcf_i2c_pkg.sv | 25 ++
 rtl/i2c_line_filter.sv | 41 ++++
 rtl/pcf_i2c_target.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/pcf_i2c_pkg.sv
// Shared types and constants for the PCF8574-style I2C target.
package pcf_i2c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_WR_DATA,
        ST_WR_ACK,
        ST_RD_DATA,
        ST_RD_ACK,
        ST_IGNORE
    } i2c_state_e;

    // PCF8574 pin roles on the HD44780 LCD backpack
    localparam int PCF_RS   = 0;
    localparam int PCF_RW   = 1;
    localparam int PCF_E    = 2;
    localparam int PCF_BL   = 3;
    localparam int PCF_D_HI = 7;
    localparam int PCF_D_LO = 4;

    localparam logic [6:0] PCF_DEF_ADDR = 7'h27;

endpackage

// File: rtl/i2c_line_filter.sv
// Synchroniser, FILT_LEN-sample glitch filter and edge detector for one I2C line.
module i2c_line_filter #(
    parameter int FILT_LEN = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic line_i,
    output logic line_f,
    output logic rise,
    output logic fall
);

    logic [1:0] sync_q;
    logic [2:0] cnt_q;

    // A level change is accepted only after FILT_LEN consecutive differing samples
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= 2'b11;
            cnt_q  <= '0;
            line_f <= 1'b1;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], line_i};
            rise   <= 1'b0;
            fall   <= 1'b0;
            if (sync_q[1] == line_f) begin
                cnt_q <= '0;
            end else if (cnt_q == 3'(FILT_LEN - 1)) begin
                cnt_q  <= '0;
                line_f <= sync_q[1];
                rise   <= sync_q[1];
                fall   <= ~sync_q[1];
            end else begin
                cnt_q <= cnt_q + 3'd1;
            end
        end
    end

endmodule

// File: rtl/pcf_i2c_target.sv
// I2C target emulating a PCF8574 expander; optional HD44780 nibble decoder
// enabled by defining PCF_LCD_DECODE_EN.
module pcf_i2c_target
    import pcf_i2c_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR = PCF_DEF_ADDR,
    parameter int         FILT_LEN = 3,
    parameter logic [7:0] PORT_RST = 8'hFF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe,
    input  logic [7:0] p_in,
    output logic [7:0] p_out,
    output logic       wr_stb,
    output logic       rd_stb,
    output logic       bus_active,
    input  logic       lcd_sync,
    output logic       lcd_valid,
    output logic [7:0] lcd_byte,
    output logic       lcd_rs
);

    logic scl_f, scl_rise, scl_fall;
    logic sda_f, sda_rise, sda_fall;

    i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_scl_filt (
        .clk(clk), .rst(rst), .line_i(scl_i),
        .line_f(scl_f), .rise(scl_rise), .fall(scl_fall)
    );

    i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_sda_filt (
        .clk(clk), .rst(rst), .line_i(sda_i),
        .line_f(sda_f), .rise(sda_rise), .fall(sda_fall)
    );

    i2c_state_e state_q, state_d;
    logic [7:0] shift_q;
    logic [3:0] bit_cnt_q;
    logic       mack_q;
    logic       start_det, stop_det, wr_commit;
    logic [7:0] wr_byte;

    assign start_det = sda_fall & scl_f;
    assign stop_det  = sda_rise & scl_f;
    assign wr_byte   = {shift_q[6:0], sda_f};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        wr_commit = 1'b0;
        if (start_det) begin
            state_d = ST_ADDR;
        end else if (stop_det) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_ADDR:
                    if (scl_fall && bit_cnt_q == 4'd8)
                        state_d = (shift_q[7:1] == DEV_ADDR) ? ST_ADDR_ACK : ST_IGNORE;
                ST_ADDR_ACK:
                    if (scl_fall) state_d = shift_q[0] ? ST_RD_DATA : ST_WR_DATA;
                ST_WR_DATA: begin
                    if (scl_rise && bit_cnt_q == 4'd7) wr_commit = 1'b1;
                    if (scl_fall && bit_cnt_q == 4'd8) state_d = ST_WR_ACK;
                end
                ST_WR_ACK:
                    if (scl_fall) state_d = ST_WR_DATA;
                ST_RD_DATA:
                    if (scl_fall && bit_cnt_q == 4'd8) state_d = ST_RD_ACK;
                ST_RD_ACK:
                    if (scl_fall) state_d = mack_q ? ST_IGNORE : ST_RD_DATA;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            mack_q     <= 1'b1;
            sda_oe     <= 1'b0;
            p_out      <= PORT_RST;
            wr_stb     <= 1'b0;
            rd_stb     <= 1'b0;
            bus_active <= 1'b0;
        end else begin
            wr_stb <= 1'b0;
            rd_stb <= 1'b0;
            if (start_det) begin
                bit_cnt_q  <= '0;
                sda_oe     <= 1'b0;
                bus_active <= 1'b1;
            end else if (stop_det) begin
                sda_oe     <= 1'b0;
                bus_active <= 1'b0;
            end else begin
                if (scl_rise) begin
                    case (state_q)
                        ST_ADDR, ST_WR_DATA: begin
                            shift_q   <= wr_byte;
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                        end
                        ST_RD_DATA: bit_cnt_q <= bit_cnt_q + 4'd1;
                        ST_RD_ACK:  mack_q <= sda_f;
                        default: ;
                    endcase
                end
                if (wr_commit) begin
                    p_out  <= wr_byte;
                    wr_stb <= 1'b1;
                end
                // SDA only moves while SCL is low
                if (scl_fall) begin
                    case (state_q)
                        ST_ADDR:
                            if (bit_cnt_q == 4'd8) sda_oe <= (shift_q[7:1] == DEV_ADDR);
                        ST_WR_DATA:
                            if (bit_cnt_q == 4'd8) sda_oe <= 1'b1;
                        ST_WR_ACK: begin
                            sda_oe    <= 1'b0;
                            bit_cnt_q <= '0;
                        end
                        ST_ADDR_ACK, ST_RD_ACK: begin
                            bit_cnt_q <= '0;
                            if ((state_q == ST_ADDR_ACK) ? shift_q[0] : ~mack_q) begin
                                shift_q <= p_in;
                                sda_oe  <= ~p_in[7];
                                rd_stb  <= 1'b1;
                            end else begin
                                sda_oe <= 1'b0;
                            end
                        end
                        ST_RD_DATA:
                            if (bit_cnt_q == 4'd8) begin
                                sda_oe <= 1'b0;
                            end else begin
                                shift_q <= {shift_q[6:0], 1'b0};
                                sda_oe  <= ~shift_q[6];
                            end
                        default: ;
                    endcase
                end
            end
        end
    end

`ifdef PCF_LCD_DECODE_EN
    logic       lcd_phase_q;
    logic [3:0] lcd_hi_q;

    // A nibble is taken on each E falling edge of a write (RW low)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lcd_phase_q <= 1'b0;
            lcd_hi_q    <= '0;
            lcd_valid   <= 1'b0;
            lcd_byte    <= '0;
            lcd_rs      <= 1'b0;
        end else begin
            lcd_valid <= 1'b0;
            if (lcd_sync) begin
                lcd_phase_q <= 1'b0;
            end else if (wr_commit && p_out[PCF_E] && !wr_byte[PCF_E] && !wr_byte[PCF_RW]) begin
                if (!lcd_phase_q) begin
                    lcd_hi_q    <= wr_byte[PCF_D_HI:PCF_D_LO];
                    lcd_phase_q <= 1'b1;
                end else begin
                    lcd_byte    <= {lcd_hi_q, wr_byte[PCF_D_HI:PCF_D_LO]};
                    lcd_rs      <= wr_byte[PCF_RS];
                    lcd_valid   <= 1'b1;
                    lcd_phase_q <= 1'b0;
                end
            end
        end
    end
`else
    logic unused_lcd_sync;
    assign unused_lcd_sync = lcd_sync;
    assign lcd_valid = 1'b0;
    assign lcd_byte  = 8'h00;
    assign lcd_rs    = 1'b0;
`endif

endmodule
